fetch_prefetch_unit: RTL



---
 rtl/fetch_prefetch_unit.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/fetch_prefetch_unit.sv
// Instruction fetch front end: PC sequencing, imem request/grant, in-order responses into a prefetch FIFO.
// Latency: response to out_valid is 1 cycle; optional FETCH_PERF_EN adds fetched/dropped counters.
// Backpressure: requests are credit-limited so outstanding plus buffered never exceeds DEPTH.
module fetch_prefetch_unit #(
  parameter int                ADDR_W   = 64,
  parameter int                DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_dropped
`endif
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

  typedef enum logic {FETCH, FLUSH} state_t;

  typedef struct packed {
    logic [31:0]       instr;
    logic [ADDR_W-1:0] pc;
  } entry_t;

  state_t            state;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] rsp_pc;
  logic [CNT_W-1:0]  outstanding;
  logic [CNT_W-1:0]  drop;
  logic [CNT_W-1:0]  count;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  entry_t            mem [DEPTH];

  logic              rsp_fire;
  logic              gnt_fire;
  logic              push;
  logic              pop;
  logic              can_issue;
  logic [CNT_W:0]    credit_used;
  logic [CNT_W-1:0]  drop_left;
  logic [CNT_W-1:0]  out_next;
  logic [ADDR_W-1:0] redirect_tgt;

  // A response with nothing outstanding is illegal and must not disturb any counter.
  assign rsp_fire     = imem_rvalid && (outstanding != '0);
  assign credit_used  = {1'b0, outstanding} + {1'b0, count};
  assign drop_left    = (rsp_fire && drop != '0) ? drop - CNT_W'(1) : drop;
  assign redirect_tgt = redirect_pc & ~ADDR_W'(3);

  // The flush exit cycle already issues, so the last stale response costs no bubble.
  assign can_issue = (state == FETCH) ? (credit_used < DEPTH_C) : (drop_left == '0);
  assign imem_req  = !reset && !redirect && can_issue;
  assign imem_addr = fetch_pc;
  assign gnt_fire  = imem_req && imem_gnt;

  assign push     = (state == FETCH) && !redirect && rsp_fire;
  assign out_valid = (count != '0);
  assign pop      = out_valid && out_ready && !redirect;
  assign out_next = outstanding + CNT_W'(gnt_fire) - CNT_W'(rsp_fire);

  assign out_instr = out_valid ? mem[rd_ptr].instr : '0;
  assign out_pc    = out_valid ? mem[rd_ptr].pc    : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= FETCH;
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else begin
      outstanding <= out_next;
      if (push) begin
        mem[wr_ptr] <= '{instr: imem_rdata, pc: rsp_pc};
      end
      if (redirect) begin
        fetch_pc <= redirect_tgt;
        rsp_pc   <= redirect_tgt;
        count    <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
      end else begin
        if (gnt_fire) fetch_pc <= fetch_pc + ADDR_W'(4);
        if (push) begin
          rsp_pc <= rsp_pc + ADDR_W'(4);
          wr_ptr <= wr_ptr + PTR_W'(1);
        end
        if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
        count <= count + CNT_W'(push) - CNT_W'(pop);
      end
      case (state)
        FETCH: begin
          if (redirect) begin
            drop  <= out_next;
            state <= (out_next != '0) ? FLUSH : FETCH;
          end
        end
        FLUSH: begin
          drop  <= drop_left;
          state <= (drop_left == '0) ? FETCH : FLUSH;
        end
        default: state <= FETCH;
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  logic [CNT_W:0] drop_inc;
  logic [32:0]    fetched_sum;
  logic [32:0]    dropped_sum;

  // Drops are discarded responses plus whatever a redirect wipes from the buffer.
  assign drop_inc    = {{CNT_W{1'b0}}, (rsp_fire && !push)} + (redirect ? {1'b0, count} : '0);
  assign fetched_sum = {1'b0, perf_fetched} + 33'(push);
  assign dropped_sum = {1'b0, perf_dropped} + 33'(drop_inc);

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched <= '0;
      perf_dropped <= '0;
    end else begin
      perf_fetched <= fetched_sum[32] ? '1 : fetched_sum[31:0];
      perf_dropped <= dropped_sum[32] ? '1 : dropped_sum[31:0];
    end
  end
`endif

  assert property (@(posedge clk) disable iff (reset) !(imem_rvalid && outstanding == '0));

endmodule
